// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Accepts mult/multu/div/divu from the E stage, runs 32 shift-add
// (multiply) or restoring shift-subtract (divide) iterations, and
// writes {HI,LO} on completion. Divide by zero resolves immediately
// (HI = dividend, LO = all ones) without entering the divide state.
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   - mult/multu complete combinationally at the accept edge
//   undefined - 32-cycle iterative multiply
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous reset, active low
//   muldivE      E-stage instruction is a mult/div
//   alucontrolE  op select: 1000 mult, 1001 multu, 1010 div, 1011 divu
//   srcaE/srcbE  rs / rt operands
//   mfhiM/mfloM  M-stage HI/LO read select
//   mdresultM    HI if mfhiM else LO (combinational)
//   hi/lo        HI/LO registers
//   busy         operation in flight
//   stallmd      stall request to the hazard unit
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             muldivE,
  input  logic [3:0]       alucontrolE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mfhiM,
  input  logic             mfloM,
  output logic [WIDTH-1:0] mdresultM,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stallmd
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;       // |multiplicand|
  logic [WIDTH-1:0]     b_q, b_d;       // |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;   // {partial, multiplier} or {remainder, dividend/quotient}
  logic                 neg_lo_q, neg_lo_d;  // product / quotient sign
  logic                 neg_hi_q, neg_hi_d;  // remainder sign (dividend sign)
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Decode of the incoming op
  logic             op_valid, op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_valid  = muldivE && (alucontrolE[3:2] == 2'b10);
  assign op_div    = alucontrolE[1];
  assign op_signed = ~alucontrolE[0];
  assign a_neg     = op_signed & srcaE[WIDTH-1];
  assign b_neg     = op_signed & srcbE[WIDTH-1];
  assign abs_a     = a_neg ? -srcaE : srcaE;
  assign abs_b     = b_neg ? -srcbE : srcbE;

  // Shift-add step: conditionally add the multiplicand into the upper
  // half (keeping the carry), then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift left one, trial-subtract the divisor
  // from the (WIDTH+1)-bit partial remainder, keep it if non-negative.
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_next = div_diff[WIDTH]
                  ? {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_fast;
  assign prod_fast = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d      = abs_a;
          b_d      = abs_b;
          cnt_d    = '0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          if (op_div) begin
            if (srcbE == '0) begin
              hi_d = srcaE;
              lo_d = '1;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, abs_a};
              state_d = DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = (a_neg ^ b_neg) ? -prod_fast : prod_fast;
`else
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            state_d = MUL;
`endif
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          state_d      = IDLE;
          {hi_d, lo_d} = neg_lo_q ? -mul_next : mul_next;
        end
      end
      DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          lo_d    = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
          hi_d    = neg_hi_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign stallmd   = busy & (muldivE | mfhiM | mfloM);
  assign mdresultM = mfhiM ? hi_q : lo_q;

endmodule
